// File: rtl/spgd_pkg.sv
// Shared definitions for the SPGD dither-step controller: state encoding,
// 16Q48 fixed-point constants and the DAC-code clamp helper.
package spgd_pkg;

  // Controller states; the numeric values are read back over GPIO.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_APPLY_P = 3'd1,
    S_WAIT_P  = 3'd2,
    S_APPLY_M = 3'd3,
    S_WAIT_M  = 3'd4,
    S_MUL     = 3'd5,
    S_ADD     = 3'd6
  } spgd_state_e;

  // 16Q48: 48 fractional bits, so 1.0 is 2^48.
  localparam int FRAC_BITS = 48;
  localparam logic signed [63:0] ONE_Q48 = 64'sh0001_0000_0000_0000;

  // A Q48 x Q48 product carries 96 fractional bits; dropping them yields
  // whole DAC LSBs rounded toward minus infinity.
  localparam int PROD_SHIFT = 2 * FRAC_BITS;

  // Working width for code arithmetic: wide enough that code +/- amplitude
  // and code + step can never wrap before the clamp sees them.
  localparam int CLAMP_W = 64;

  // Saturate a signed candidate code into [0, hi].
  function automatic logic signed [CLAMP_W-1:0] clamp_code(
    input logic signed [CLAMP_W-1:0] v,
    input logic signed [CLAMP_W-1:0] hi
  );
    if (v < 0)  return '0;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/spgd_dither_step_if.sv
// Host-side signal bundle for spgd_dither_step. The controller keeps its
// flat, named ports; this interface groups the control/metric bus for the
// agent that drives it (master) and the block that consumes it (slave).
interface spgd_dither_step_if #(
  parameter int FLOAT_WIDTH  = 64,
  parameter int DAC_WIDTH    = 14,
  parameter int SETTLE_WIDTH = 16
);
  logic                          enable;
  logic                          u_load;
  logic        [DAC_WIDTH-1:0]   u_init;
  logic signed [FLOAT_WIDTH-1:0] metric_in;
  logic                          metric_valid;
  logic        [DAC_WIDTH-1:0]   dither_amp;
  logic signed [FLOAT_WIDTH-1:0] gain;
  logic        [SETTLE_WIDTH-1:0] settle_cycles;
  logic        [DAC_WIDTH-1:0]   dac_code;
  logic        [DAC_WIDTH-1:0]   u_out;
  logic                          busy;
  logic                          step_done;
  logic        [2:0]             state;

  modport master (
    output enable, u_load, u_init, metric_in, metric_valid,
           dither_amp, gain, settle_cycles,
    input  dac_code, u_out, busy, step_done, state
  );

  modport slave (
    input  enable, u_load, u_init, metric_in, metric_valid,
           dither_amp, gain, settle_cycles,
    output dac_code, u_out, busy, step_done, state
  );
endinterface

// File: rtl/spgd_settle_cnt.sv
// Settle counter: loaded with the settle time when a DAC code is applied,
// counts down to zero while waiting, and flags zero so a metric strobe
// may be accepted.
module spgd_settle_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  // Load on apply, otherwise count down to zero and stop there.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/spgd_dither_step.sv
// SPGD dither-step controller. Each iteration applies U+A, waits for the
// plant to settle and latches the metric Jp, applies U-A and latches Jm,
// then updates U by floor(GAIN*(Jp-Jm)) in DAC LSBs with saturation.
// Build option: define SPGD_STEP_LIMIT_EN to clamp each step to
// [-MAX_STEP, +MAX_STEP] before it is added to U.
module spgd_dither_step
  import spgd_pkg::*;
#(
  parameter int FLOAT_WIDTH  = 64,
  parameter int DAC_WIDTH    = 14,
  parameter int SETTLE_WIDTH = 16,
  parameter int MAX_STEP     = 64
) (
  input  logic                          ADC_CLK,
  input  logic                          ADC_RSTN,
  input  logic                          enable,
  input  logic                          U_LOAD,
  input  logic        [DAC_WIDTH-1:0]   U_INIT,
  input  logic signed [FLOAT_WIDTH-1:0] METRIC_IN,
  input  logic                          METRIC_VALID,
  input  logic        [DAC_WIDTH-1:0]   DITHER_AMP,
  input  logic signed [FLOAT_WIDTH-1:0] GAIN,
  input  logic        [SETTLE_WIDTH-1:0] SETTLE_CYCLES,
  output logic        [DAC_WIDTH-1:0]   DAC_CODE_OUT,
  output logic        [DAC_WIDTH-1:0]   U_OUT,
  output logic                          BUSY,
  output logic                          STEP_DONE,
  output logic        [2:0]             STATE_OUT
);

  localparam int PROD_W = 2 * FLOAT_WIDTH + 1;
  localparam int STEP_W = PROD_W - PROD_SHIFT;

  localparam logic signed [CLAMP_W-1:0] CODE_MAX =
    CLAMP_W'((64'sd1 <<< DAC_WIDTH) - 64'sd1);
  localparam logic signed [CLAMP_W-1:0] STEP_HI = CLAMP_W'(MAX_STEP);
  localparam logic signed [CLAMP_W-1:0] STEP_LO = -STEP_HI;

`ifdef SPGD_STEP_LIMIT_EN
  localparam bit STEP_LIMIT = 1'b1;
`else
  localparam bit STEP_LIMIT = 1'b0;
`endif

  spgd_state_e                   state;
  logic        [DAC_WIDTH-1:0]   u;
  logic        [DAC_WIDTH-1:0]   dac;
  logic signed [FLOAT_WIDTH-1:0] jp;
  logic signed [FLOAT_WIDTH-1:0] jm;
  logic signed [PROD_W-1:0]      prod;
  logic                          step_done;
  logic [1:0]                    rst_sync;
  logic                          rst_n;

  // Reset asserts immediately and releases two clock edges later.
  always_ff @(posedge ADC_CLK or negedge ADC_RSTN) begin
    if (!ADC_RSTN) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  assign cnt_load = (state == S_APPLY_P) || (state == S_APPLY_M);
  assign cnt_dec  = (state == S_WAIT_P)  || (state == S_WAIT_M);

  spgd_settle_cnt #(.WIDTH(SETTLE_WIDTH)) u_settle (
    .clk      (ADC_CLK),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (SETTLE_CYCLES),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Code arithmetic is done in a wide signed domain so nothing wraps.
  logic signed [CLAMP_W-1:0]   u_ext;
  logic signed [CLAMP_W-1:0]   amp_ext;
  logic signed [FLOAT_WIDTH:0] diff;
  logic signed [PROD_W-1:0]    gain_x;
  logic signed [PROD_W-1:0]    diff_x;
  logic signed [PROD_W-1:0]    prod_next;
  logic signed [STEP_W-1:0]    step;
  logic signed [CLAMP_W-1:0]   step_ext;
  logic signed [CLAMP_W-1:0]   step_lim;
  logic        [DAC_WIDTH-1:0] code_p;
  logic        [DAC_WIDTH-1:0] code_m;
  logic        [DAC_WIDTH-1:0] code_add;

  assign u_ext   = {{(CLAMP_W-DAC_WIDTH){1'b0}}, u};
  assign amp_ext = {{(CLAMP_W-DAC_WIDTH){1'b0}}, DITHER_AMP};
  assign code_p  = DAC_WIDTH'(clamp_code(u_ext + amp_ext, CODE_MAX));
  assign code_m  = DAC_WIDTH'(clamp_code(u_ext - amp_ext, CODE_MAX));

  // Metric difference one bit wider than the operands, product full width.
  assign diff      = {jp[FLOAT_WIDTH-1], jp} - {jm[FLOAT_WIDTH-1], jm};
  assign gain_x    = {{(FLOAT_WIDTH+1){GAIN[FLOAT_WIDTH-1]}}, GAIN};
  assign diff_x    = {{FLOAT_WIDTH{diff[FLOAT_WIDTH]}}, diff};
  assign prod_next = gain_x * diff_x;

  // Taking the bits above the fraction is a floor toward minus infinity.
  assign step     = prod[PROD_W-1:PROD_SHIFT];
  assign step_ext = {{(CLAMP_W-STEP_W){step[STEP_W-1]}}, step};

  // Optional symmetric step limit ahead of the U update.
  always_comb begin
    // NOTE: assign a default before any condition so every path drives the
    // signal; a path that leaves it unassigned would infer a latch.
    step_lim = step_ext;
    if (STEP_LIMIT) begin
      if (step_ext > STEP_HI)      step_lim = STEP_HI;
      else if (step_ext < STEP_LO) step_lim = STEP_LO;
    end
  end

  assign code_add = DAC_WIDTH'(clamp_code(u_ext + step_lim, CODE_MAX));

  // Iteration sequencer; dropping enable outside IDLE and ADD abandons the
  // iteration, parks the DAC on U and discards the captured metrics.
  always_ff @(posedge ADC_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      u         <= '0;
      dac       <= '0;
      jp        <= '0;
      jm        <= '0;
      prod      <= '0;
      step_done <= 1'b0;
    end else begin
      step_done <= 1'b0;
      if (!enable && (state != S_IDLE) && (state != S_ADD)) begin
        state <= S_IDLE;
        dac   <= u;
        jp    <= '0;
        jm    <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (U_LOAD) u <= U_INIT;
            if (enable) state <= S_APPLY_P;
          end
          S_APPLY_P: begin
            dac   <= code_p;
            state <= S_WAIT_P;
          end
          S_WAIT_P: begin
            if (cnt_zero && METRIC_VALID) begin
              jp    <= METRIC_IN;
              state <= S_APPLY_M;
            end
          end
          S_APPLY_M: begin
            dac   <= code_m;
            state <= S_WAIT_M;
          end
          S_WAIT_M: begin
            if (cnt_zero && METRIC_VALID) begin
              jm    <= METRIC_IN;
              state <= S_MUL;
            end
          end
          S_MUL: begin
            prod  <= prod_next;
            state <= S_ADD;
          end
          S_ADD: begin
            u         <= code_add;
            dac       <= code_add;
            step_done <= 1'b1;
            state     <= enable ? S_APPLY_P : S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign DAC_CODE_OUT = dac;
  assign U_OUT        = u;
  assign BUSY         = (state != S_IDLE);
  assign STEP_DONE    = step_done;
  assign STATE_OUT    = state;

endmodule

// File: tb/tb_spgd_dither_step.sv
// Self-checking bench for spgd_dither_step: directed vector table, hand
// sequences for the multi-cycle corners, and randomized iterations checked
// against an arithmetic reference model.
module tb_spgd_dither_step;
  import spgd_pkg::*;

  logic clk;
  logic rst_n;

  spgd_dither_step_if bus ();

  spgd_dither_step dut (
    .ADC_CLK       (clk),
    .ADC_RSTN      (rst_n),
    .enable        (bus.enable),
    .U_LOAD        (bus.u_load),
    .U_INIT        (bus.u_init),
    .METRIC_IN     (bus.metric_in),
    .METRIC_VALID  (bus.metric_valid),
    .DITHER_AMP    (bus.dither_amp),
    .GAIN          (bus.gain),
    .SETTLE_CYCLES (bus.settle_cycles),
    .DAC_CODE_OUT  (bus.dac_code),
    .U_OUT         (bus.u_out),
    .BUSY          (bus.busy),
    .STEP_DONE     (bus.step_done),
    .STATE_OUT     (bus.state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  localparam longint CODE_TOP = 16383;

  function automatic longint model_clamp(input longint v);
    if (v < 0)        return 0;
    if (v > CODE_TOP) return CODE_TOP;
    return v;
  endfunction

  // floor(GAIN * (Jp - Jm)) with all three as real numbers scaled by 2^48.
  function automatic longint model_step(input logic signed [63:0] g,
                                        input logic signed [63:0] a,
                                        input logic signed [63:0] b);
    logic signed [128:0] gw, dw, p, den, q, r;
    gw  = 129'(g);
    dw  = 129'(a);
    dw  = dw - 129'(b);
    p   = gw * dw;
    den = 129'sd1;
    den = den <<< 96;
    q   = p / den;
    r   = p % den;
    if (r != 0 && p < 0) q = q - 1;
`ifdef SPGD_STEP_LIMIT_EN
    if (q > 64)  q = 64;
    if (q < -64) q = -64;
`endif
    return longint'(q);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic load_u(input logic [13:0] v);
    bus.u_init = v;
    bus.u_load = 1'b1;
    tick();
    bus.u_load = 1'b0;
  endtask

  // One full iteration with METRIC_VALID held high; reports the plus/minus
  // DAC codes, new U, edges from enable to STEP_DONE, and the state/DAC one
  // edge after enable is dropped.
  task automatic run_iter(input logic [13:0] uinit, input logic [13:0] amp,
                          input logic [15:0] settle, input logic signed [63:0] g,
                          input logic signed [63:0] a, input logic signed [63:0] b,
                          output longint dp, output longint dm, output longint un,
                          output int cyc, output longint d_idle, output longint s_idle);
    bus.enable = 1'b0;
    load_u(uinit);
    bus.dither_amp    = amp;
    bus.settle_cycles = settle;
    bus.gain          = g;
    bus.metric_in     = a;
    bus.metric_valid  = 1'b1;
    bus.enable        = 1'b1;
    dp = -1; dm = -1; un = -1; cyc = 0;
    while (cyc < 300) begin
      tick();
      cyc++;
      if (bus.state == 3'd2) begin dp = bus.dac_code; bus.metric_in = a; end
      if (bus.state == 3'd4) begin dm = bus.dac_code; bus.metric_in = b; end
      if (bus.step_done) begin un = bus.u_out; break; end
    end
    bus.metric_valid = 1'b0;
    bus.enable       = 1'b0;
    tick();
    d_idle = bus.dac_code;
    s_idle = bus.state;
  endtask

  typedef struct {
    logic [13:0]        u_init;
    logic [13:0]        amp;
    logic [15:0]        settle;
    logic signed [63:0] gain;
    logic signed [63:0] jp;
    logic signed [63:0] jm;
    longint             exp_dp;
    longint             exp_dm;
    longint             exp_u;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic signed [63:0] q16, q05, q4096, q003;
    longint dp, dm, un, d_idle, s_idle;
    int cyc;
    int guard;

    q16   = ONE_Q48 <<< 4;
    q05   = ONE_Q48 >>> 1;
    q4096 = ONE_Q48 <<< 12;
    q003  = 64'sd8444249301320;   // 0.03 in 16Q48

    rst_n                = 1'b0;
    bus.enable           = 1'b0;
    bus.u_load           = 1'b0;
    bus.u_init           = '0;
    bus.metric_in        = '0;
    bus.metric_valid     = 1'b0;
    bus.dither_amp       = '0;
    bus.gain             = '0;
    bus.settle_cycles    = '0;

    repeat (3) tick();
    check("rst_dac",   bus.dac_code,  0);
    check("rst_u",     bus.u_out,     0);
    check("rst_state", bus.state,     0);
    check("rst_busy",  bus.busy,      0);
    check("rst_done",  bus.step_done, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // ---------------- directed vector table ----------------
    vecs[0] = '{14'd8192, 14'd100, 16'd4, q16, ONE_Q48, q05, 8292, 8092, 8200};
    vecs[1] = '{14'd8192, 14'd100, 16'd4, q16, q05, ONE_Q48, 8292, 8092, 8184};
    vecs[2] = '{14'd8192, 14'd100, 16'd0, ONE_Q48, 64'sd0, q003, 8292, 8092, 8191};
    vecs[3] = '{14'd16380, 14'd100, 16'd2, 64'sd0, ONE_Q48, q05, 16383, 16280, 16380};
    vecs[4] = '{14'd50, 14'd100, 16'd1, 64'sd0, ONE_Q48, q05, 150, 0, 50};
    vecs[5] = '{14'd10, 14'd5, 16'd0, q16, 64'sd0, ONE_Q48, 15, 5, 0};
`ifdef SPGD_STEP_LIMIT_EN
    vecs[6] = '{14'd16000, 14'd10, 16'd1, q4096, ONE_Q48, 64'sd0, 16010, 15990, 16064};
    vecs[7] = '{14'd8192, 14'd10, 16'd3, q4096, ONE_Q48, 64'sd0, 8202, 8182, 8256};
`else
    vecs[6] = '{14'd16000, 14'd10, 16'd1, q4096, ONE_Q48, 64'sd0, 16010, 15990, 16383};
    vecs[7] = '{14'd8192, 14'd10, 16'd3, q4096, ONE_Q48, 64'sd0, 8202, 8182, 12288};
`endif

    for (int i = 0; i < 8; i++) begin
      run_iter(vecs[i].u_init, vecs[i].amp, vecs[i].settle, vecs[i].gain,
               vecs[i].jp, vecs[i].jm, dp, dm, un, cyc, d_idle, s_idle);
      check($sformatf("vec%0d_dac_plus", i),  dp, vecs[i].exp_dp);
      check($sformatf("vec%0d_dac_minus", i), dm, vecs[i].exp_dm);
      check($sformatf("vec%0d_u", i),         un, vecs[i].exp_u);
      check($sformatf("vec%0d_cycles", i),    cyc, 2 * vecs[i].settle + 7);
      check($sformatf("vec%0d_idle_dac", i),  d_idle, vecs[i].exp_u);
      check($sformatf("vec%0d_idle_state", i), s_idle, 0);
    end

    // ---------------- strobe during settle ignored; U_LOAD ignored when busy ----
    load_u(14'd8192);
    bus.dither_amp    = 14'd100;
    bus.settle_cycles = 16'd4;
    bus.gain          = q16;
    bus.metric_valid  = 1'b0;
    bus.enable        = 1'b1;
    tick();
    check("seqb_apply_p", bus.state, 1);
    tick();                                   // WAIT_P, count 4
    check("seqb_wait_p", bus.state, 2);
    check("seqb_dac_p", bus.dac_code, 8292);
    tick();                                   // count 3
    tick();                                   // count 2
    bus.metric_valid = 1'b1;
    bus.metric_in    = -ONE_Q48;
    bus.u_load       = 1'b1;
    bus.u_init       = 14'd5;
    tick();                                   // count 1
    check("seqb_early_strobe_ignored", bus.state, 2);
    bus.metric_valid = 1'b0;
    bus.u_load       = 1'b0;
    tick();                                   // count 0
    check("seqb_still_waiting", bus.state, 2);
    bus.metric_valid = 1'b1;
    bus.metric_in    = ONE_Q48;
    tick();
    check("seqb_jp_latched", bus.state, 3);
    bus.metric_valid = 1'b0;
    tick();                                   // WAIT_M, count 4
    check("seqb_dac_m", bus.dac_code, 8092);
    repeat (4) tick();                        // count 0
    bus.metric_valid = 1'b1;
    bus.metric_in    = q05;
    tick();
    check("seqb_mul", bus.state, 5);
    bus.metric_valid = 1'b0;
    tick();
    check("seqb_add", bus.state, 6);
    tick();
    check("seqb_step_done", bus.step_done, 1);
    check("seqb_u", bus.u_out, 8200);
    bus.enable = 1'b0;
    tick();
    check("seqb_done_one_cycle", bus.step_done, 0);

    // ---------------- enable dropped in WAIT_P ----------------
    load_u(14'd500);
    bus.settle_cycles = 16'd8;
    bus.enable        = 1'b1;
    tick();
    tick();
    check("seqc_dac_p", bus.dac_code, 600);
    bus.enable = 1'b0;
    tick();
    check("seqc_state", bus.state, 0);
    check("seqc_dac",   bus.dac_code, 500);
    check("seqc_u",     bus.u_out, 500);
    check("seqc_busy",  bus.busy, 0);
    check("seqc_done",  bus.step_done, 0);

    // ---------------- enable dropped in ADD still commits ----------------
    load_u(14'd8192);
    bus.dither_amp    = 14'd10;
    bus.settle_cycles = 16'd1;
    bus.gain          = q16;
    bus.metric_valid  = 1'b1;
    bus.metric_in     = ONE_Q48;
    bus.enable        = 1'b1;
    guard = 0;
    while (bus.state != 3'd6 && guard < 50) begin
      tick();
      guard++;
      if (bus.state == 3'd4) bus.metric_in = q05;
    end
    check("seqd_reach_add", (guard < 50) ? 1 : 0, 1);
    bus.enable       = 1'b0;
    bus.metric_valid = 1'b0;
    tick();
    check("seqd_done",  bus.step_done, 1);
    check("seqd_u",     bus.u_out, 8200);
    check("seqd_dac",   bus.dac_code, 8200);
    check("seqd_state", bus.state, 0);

    // ---------------- reset mid-WAIT_M ----------------
    load_u(14'd1000);
    bus.dither_amp    = 14'd50;
    bus.settle_cycles = 16'd10;
    bus.metric_valid  = 1'b1;
    bus.metric_in     = ONE_Q48;
    bus.enable        = 1'b1;
    guard = 0;
    while (bus.state != 3'd4 && guard < 50) begin
      tick();
      guard++;
    end
    check("seqa_reach_wait_m", (guard < 50) ? 1 : 0, 1);
    #2 rst_n = 1'b0;
    #1;
    check("seqa_dac",   bus.dac_code, 0);
    check("seqa_u",     bus.u_out, 0);
    check("seqa_state", bus.state, 0);
    check("seqa_busy",  bus.busy, 0);
    bus.enable       = 1'b0;
    bus.metric_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    guard = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.step_done) guard++;
    end
    check("seqa_no_step_done", guard, 0);

    // ---------------- randomized iterations vs model ----------------
    for (int i = 0; i < 24; i++) begin
      logic [13:0]        ru, ra;
      logic [15:0]        rs;
      logic signed [63:0] rg, rjp, rjm;
      longint             st, eu;
      ru  = 14'($urandom_range(0, 16383));
      ra  = 14'($urandom_range(0, 400));
      rs  = 16'($urandom_range(0, 3));
      rg  = $signed({$urandom(), $urandom()}) >>> ((i % 4 == 0) ? 4 : 10);
      rjp = $signed({$urandom(), $urandom()}) >>> 12;
      rjm = $signed({$urandom(), $urandom()}) >>> 12;
      st  = model_step(rg, rjp, rjm);
      eu  = model_clamp(longint'(ru) + st);
      run_iter(ru, ra, rs, rg, rjp, rjm, dp, dm, un, cyc, d_idle, s_idle);
      check($sformatf("rnd%0d_dac_plus", i),  dp, model_clamp(longint'(ru) + longint'(ra)));
      check($sformatf("rnd%0d_dac_minus", i), dm, model_clamp(longint'(ru) - longint'(ra)));
      check($sformatf("rnd%0d_u", i),         un, eu);
      check($sformatf("rnd%0d_cycles", i),    cyc, 2 * rs + 7);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spgd_dither_step.md
SPGD_DITHER_STEP -- requirements
Module: spgd_dither_step

Interface
REQ-001 Parameters SHALL be: FLOAT_WIDTH, 64, 16Q48 signed metric/gain word; DAC_WIDTH, 14, unsigned DAC code width; SETTLE_WIDTH, 16, settle counter width; MAX_STEP, 64, per-iteration step limit in DAC LSBs.
REQ-002 Ports SHALL be (name direction width meaning):
- ADC_CLK  in  1  sole clock.
- ADC_RSTN  in  1  asynchronous, active-low reset.
- enable  in  1  run request.
- U_LOAD  in  1  pulse; load U_INIT into control word.
- U_INIT  in  DAC_WIDTH  initial control code.
- METRIC_IN  in  FLOAT_WIDTH  16Q48 signed metric from the ADC capture path.
- METRIC_VALID  in  1  one-cycle strobe qualifying METRIC_IN.
- DITHER_AMP  in  DAC_WIDTH  perturbation amplitude, LSBs.
- GAIN  in  FLOAT_WIDTH  16Q48 signed update gain.
- SETTLE_CYCLES  in  SETTLE_WIDTH  wait after each DAC change.
- DAC_CODE_OUT  out  DAC_WIDTH  registered code to DAC.
- U_OUT  out  DAC_WIDTH  current control word.
- BUSY  out  1  high in any state except IDLE.
- STEP_DONE  out  1  one-cycle pulse per completed iteration.
- STATE_OUT  out  3  state encoding for GPIO readback.

Function
REQ-003 States SHALL be IDLE(0), APPLY_P(1), WAIT_P(2), APPLY_M(3), WAIT_M(4), MUL(5), ADD(6).
REQ-004 IDLE SHALL go to APPLY_P when enable=1; U_LOAD in IDLE SHALL load U_INIT into U the same edge; U_LOAD outside IDLE SHALL be ignored.
REQ-005 APPLY_P SHALL register DAC_CODE_OUT = clamp(U + DITHER_AMP, 0, 2^DAC_WIDTH-1), load settle counter with SETTLE_CYCLES, go to WAIT_P; APPLY_M identical with U - DITHER_AMP, to WAIT_M.
REQ-006 WAIT_P/WAIT_M SHALL decrement the counter each cycle until zero; METRIC_VALID while counter nonzero SHALL be ignored; first METRIC_VALID with counter zero SHALL latch METRIC_IN as Jp (WAIT_P -> APPLY_M) or Jm (WAIT_M -> MUL).
REQ-007 SETTLE_CYCLES=0 SHALL accept METRIC_VALID on the first WAIT cycle.
REQ-008 MUL SHALL register prod = GAIN x (Jp - Jm), difference computed at FLOAT_WIDTH+1 bits, product full-width signed.
REQ-009 ADD SHALL form step = prod arithmetic-shifted right by 96 (integer DAC LSBs, truncation toward minus infinity), U = clamp(U + step, 0, 2^DAC_WIDTH-1), register DAC_CODE_OUT = new U, go to APPLY_P if enable else IDLE.
REQ-010 STEP_DONE SHALL pulse exactly one cycle, the cycle after ADD.
REQ-011 enable=0 in any non-IDLE state SHALL go to IDLE next edge, set DAC_CODE_OUT = U, retain U, discard Jp/Jm; no STEP_DONE.
REQ-012 enable deassert coinciding with ADD SHALL still commit the U update.
REQ-013 Clamp SHALL never wrap: U + DITHER_AMP overflow -> 2^DAC_WIDTH-1, underflow -> 0.

Reset
REQ-014 ADC_RSTN low SHALL asynchronously force state IDLE, U=0, DAC_CODE_OUT=0, Jp=Jm=0, counter=0, STEP_DONE=0, BUSY=0; release is synchronised to ADC_CLK.
REQ-015 Reset mid-iteration SHALL abandon it with no STEP_DONE.

Configuration
REQ-016 With SPGD_STEP_LIMIT_EN defined, step SHALL be clamped to [-MAX_STEP, +MAX_STEP] before the U add; without it, step SHALL be limited only by REQ-009 saturation.

Structure
REQ-017 State encoding, 16Q48 ONE constant, and a clamp function SHALL live in shared package spgd_pkg.
REQ-018 Settle counter SHALL be sub-module spgd_settle_cnt (load, zero flag); the rest in one module.

Verification
REQ-019 Bench SHALL cover:
- Reset asserted mid-WAIT_M -> DAC_CODE_OUT=0, U_OUT=0, STATE_OUT=0, BUSY=0 immediately.
- U_LOAD U_INIT=8192, DITHER_AMP=100, SETTLE=4, GAIN=16.0, Jp=1.0, Jm=0.5 -> DAC 8292, then 8092, U_OUT=8200, one STEP_DONE.
- Jp=0.5, Jm=1.0, GAIN=16.0 -> U 8192 -> 8184; GAIN=1.0 with Jp-Jm=-0.03 -> step -1.
- U=16380, DITHER_AMP=100 -> DAC_CODE_OUT=16383; U=50 -> minus phase 0.
- METRIC_VALID at settle count 2 ignored, next strobe at count 0 latched; enable dropped in WAIT_P -> IDLE next cycle, DAC=U.
- GAIN=4096.0, Jp-Jm=1.0 -> step +64 with SPGD_STEP_LIMIT_EN, U saturates at 16383 without.
